// File: rtl/ram_fifo.sv
// Parametrised N-word x W-bit queue on an enable-gated flip-flop array, with count,
// full/empty status and sticky overflow/underflow flags. Define RAM_FIFO_PEEK_EN to add PA/PY peek.
module ram_fifo #(
  parameter int N = 8,
  parameter int W = 4,
  localparam int G = $clog2(N),
  localparam int K = $clog2(N + 1)
) (
  input  logic         C,
  input  logic         nR,
  input  logic         CLR,
  input  logic         WR,
  input  logic         RD,
  input  logic [W-1:0] D,
`ifdef RAM_FIFO_PEEK_EN
  input  logic [G-1:0] PA,
  output logic [W-1:0] PY,
`endif
  output logic [W-1:0] Y,
  output logic         EMPTY,
  output logic         FULL,
  output logic [K-1:0] CNT,
  output logic         OVF,
  output logic         UNF
);

  localparam logic [G-1:0] LAST  = G'(N - 1);
  localparam logic [K-1:0] DEPTH = K'(N);

  logic [W-1:0] r_mem [N];
  logic [G-1:0] r_head;
  logic [G-1:0] r_tail;
  logic [K-1:0] r_cnt;
  logic         r_ovf;
  logic         r_unf;

  logic w_full;
  logic w_empty;
  logic w_run;
  logic w_push;
  logic w_pop;

  function automatic logic [G-1:0] wrap_inc(input logic [G-1:0] p);
    return (p == LAST) ? '0 : p + G'(1);
  endfunction

  assign w_full  = (r_cnt == DEPTH);
  assign w_empty = (r_cnt == '0);
  assign w_run   = nR & ~CLR;
  // When full, a simultaneous pop frees the slot the push lands in (tail == head).
  assign w_push  = WR & (~w_full | RD);
  assign w_pop   = RD & ~w_empty;

  // Storage carries no reset; a word is only written when its decoded tail enable fires.
  for (genvar i = 0; i < N; i++) begin : g_word
    always_ff @(posedge C) begin
      if (w_run && w_push && (r_tail == G'(i))) begin
        r_mem[i] <= D;
      end
    end
  end

  always_ff @(posedge C) begin
    if (!nR || CLR) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_push) r_tail <= wrap_inc(r_tail);
      if (w_pop)  r_head <= wrap_inc(r_head);
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + K'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - K'(1);
      end
      if (WR && w_full && !RD) r_ovf <= 1'b1;
      if (RD && w_empty)       r_unf <= 1'b1;
    end
  end

  assign Y     = w_empty ? '0 : r_mem[r_head];
  assign EMPTY = w_empty;
  assign FULL  = w_full;
  assign CNT   = r_cnt;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

`ifdef RAM_FIFO_PEEK_EN
  localparam logic [G:0] DEPTH_X = (G + 1)'(N);

  logic [G:0]   w_psum;
  logic [G-1:0] w_pidx;

  // head + PA is below 2N, so a single conditional subtract gives the modulo.
  assign w_psum = {1'b0, r_head} + {1'b0, PA};
  assign w_pidx = G'((w_psum >= DEPTH_X) ? (w_psum - DEPTH_X) : w_psum);
  assign PY     = (K'(PA) < r_cnt) ? r_mem[w_pidx] : '0;
`endif

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo: directed scenarios on N=8 and N=5 instances plus
// randomized traffic compared against a queue-based reference model.
module tb_ram_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nr, clr, wr, rd;
  logic [3:0] d, y, cnt;
  logic       empty, full, ovf, unf;

  logic       wr5, rd5;
  logic [3:0] d5, y5;
  logic [2:0] cnt5;
  logic       empty5, full5, ovf5, unf5;

`ifdef RAM_FIFO_PEEK_EN
  logic [2:0] pa, pa5;
  logic [3:0] py, py5;
`endif

  int vecs = 0;
  int errs = 0;

  logic [3:0] q8[$];
  logic [3:0] q5[$];
  bit         m_ovf, m_unf;

  ram_fifo #(.N(8), .W(4)) u_dut8 (
    .C(clk), .nR(nr), .CLR(clr), .WR(wr), .RD(rd), .D(d),
`ifdef RAM_FIFO_PEEK_EN
    .PA(pa), .PY(py),
`endif
    .Y(y), .EMPTY(empty), .FULL(full), .CNT(cnt), .OVF(ovf), .UNF(unf)
  );

  ram_fifo #(.N(5), .W(4)) u_dut5 (
    .C(clk), .nR(nr), .CLR(1'b0), .WR(wr5), .RD(rd5), .D(d5),
`ifdef RAM_FIFO_PEEK_EN
    .PA(pa5), .PY(py5),
`endif
    .Y(y5), .EMPTY(empty5), .FULL(full5), .CNT(cnt5), .OVF(ovf5), .UNF(unf5)
  );

  function automatic logic [3:0] head8();
    return (q8.size() != 0) ? q8[0] : 4'h0;
  endfunction

  // One clock on the N=8 instance; the queue model follows the queue rules directly.
  task automatic step(input logic w, input logic r, input logic [3:0] dat, input logic c);
    bit f, e, pu, po;
    wr = w; rd = r; d = dat; clr = c;
    if (!nr || c) begin
      q8.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      f  = (q8.size() == 8);
      e  = (q8.size() == 0);
      pu = w && (!f || r);
      po = r && !e;
      if (w && f && !r) m_ovf = 1;
      if (r && e) m_unf = 1;
      if (po) void'(q8.pop_front());
      if (pu) q8.push_back(dat);
    end
    @(posedge clk); #1;
    wr = 0; rd = 0; clr = 0;
  endtask

  task automatic step5(input logic w, input logic r, input logic [3:0] dat);
    wr5 = w; rd5 = r; d5 = dat;
    if (r && q5.size() != 0) void'(q5.pop_front());
    if (w && q5.size() < 5) q5.push_back(dat);
    @(posedge clk); #1;
    wr5 = 0; rd5 = 0;
  endtask

  task automatic test_reset();
    nr = 0;
    step(1, 1, 4'h3, 0);
    q5.delete();
    nr = 1;
    step(0, 0, 4'h0, 0);
    vecs++; if (cnt !== 4'd0)  begin errs++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
    vecs++; if (full !== 1'b0)  begin errs++; $display("FAIL reset_full got %b want 0", full); end
    vecs++; if (y !== 4'h0)     begin errs++; $display("FAIL reset_y got %h want 0", y); end
    vecs++; if (ovf !== 1'b0)   begin errs++; $display("FAIL reset_ovf got %b want 0", ovf); end
    vecs++; if (unf !== 1'b0)   begin errs++; $display("FAIL reset_unf got %b want 0", unf); end
    vecs++; if (cnt5 !== 3'd0 || empty5 !== 1'b1) begin
      errs++; $display("FAIL reset_n5 got cnt=%0d empty=%b want 0/1", cnt5, empty5);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) step(1, 0, 4'(i), 0);
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full got %b want 1", full); end
    vecs++; if (cnt !== 4'd8)  begin errs++; $display("FAIL fill_cnt got %0d want 8", cnt); end
    vecs++; if (y !== 4'h1)    begin errs++; $display("FAIL fill_y got %h want 1", y); end
    for (int i = 1; i <= 8; i++) begin
      vecs++; if (y !== 4'(i)) begin errs++; $display("FAIL drain_y[%0d] got %h want %h", i, y, 4'(i)); end
      step(0, 1, 4'h0, 0);
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL drain_empty got %b want 1", empty); end
    vecs++; if (unf !== 1'b0)   begin errs++; $display("FAIL drain_unf got %b want 0", unf); end
  endtask

  task automatic test_overflow();
    logic [3:0] want [8] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
    for (int i = 1; i <= 8; i++) step(1, 0, 4'(i), 0);
    step(1, 0, 4'h9, 0);
    vecs++; if (cnt !== 4'd8) begin errs++; $display("FAIL ovf_cnt got %0d want 8", cnt); end
    vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b want 1", ovf); end
    vecs++; if (y !== 4'h1)   begin errs++; $display("FAIL ovf_y got %h want 1", y); end
    step(1, 1, 4'hA, 0);
    vecs++; if (y !== 4'h2)   begin errs++; $display("FAIL fullrw_y got %h want 2", y); end
    vecs++; if (cnt !== 4'd8) begin errs++; $display("FAIL fullrw_cnt got %0d want 8", cnt); end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (y !== want[i]) begin errs++; $display("FAIL fullrw_pop[%0d] got %h want %h", i, y, want[i]); end
      step(0, 1, 4'h0, 0);
    end
    vecs++; if (empty !== 1'b1 || ovf !== 1'b1) begin
      errs++; $display("FAIL fullrw_end got empty=%b ovf=%b want 1/1", empty, ovf);
    end
  endtask

  task automatic test_underflow();
    wr = 1; rd = 1; d = 4'h5;
    #1;
    vecs++; if (y !== 4'h0) begin errs++; $display("FAIL nobypass_y got %h want 0", y); end
    step(1, 1, 4'h5, 0);
    vecs++; if (cnt !== 4'd1) begin errs++; $display("FAIL unf_cnt got %0d want 1", cnt); end
    vecs++; if (unf !== 1'b1) begin errs++; $display("FAIL unf_flag got %b want 1", unf); end
    vecs++; if (y !== 4'h5)   begin errs++; $display("FAIL unf_y got %h want 5", y); end
    step(1, 0, 4'h7, 1);
    vecs++; if (cnt !== 4'd0 || empty !== 1'b1) begin
      errs++; $display("FAIL clr_cnt got cnt=%0d empty=%b want 0/1", cnt, empty);
    end
    vecs++; if (unf !== 1'b0 || ovf !== 1'b0) begin
      errs++; $display("FAIL clr_flags got unf=%b ovf=%b want 0/0", unf, ovf);
    end
    vecs++; if (y !== 4'h0) begin errs++; $display("FAIL clr_y got %h want 0", y); end
  endtask

  task automatic test_wrap();
    int k = 1;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 3; i++) begin
        step5(1, 0, 4'(k));
        k++;
      end
      for (int i = 0; i < 3; i++) begin
        vecs++; if (y5 !== q5[0]) begin
          errs++; $display("FAIL wrap_y r%0d i%0d got %h want %h", round, i, y5, q5[0]);
        end
        step5(0, 1, 4'h0);
      end
      vecs++; if (cnt5 !== 3'd0 || empty5 !== 1'b1) begin
        errs++; $display("FAIL wrap_cnt r%0d got %0d want 0", round, cnt5);
      end
    end
    vecs++; if (ovf5 !== 1'b0 || unf5 !== 1'b0 || full5 !== 1'b0) begin
      errs++; $display("FAIL wrap_flags got ovf=%b unf=%b full=%b want 0/0/0", ovf5, unf5, full5);
    end
  endtask

  task automatic test_random();
    logic [11:0] act, exp;
    int pw, pr;
    for (int n = 0; n < 600; n++) begin
      pw = (n < 300) ? 70 : 30;
      pr = (n < 300) ? 35 : 70;
      step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
           4'($urandom), 1'($urandom_range(0, 63) == 0));
      act = {y, cnt, empty, full, ovf, unf};
      exp = {head8(), 4'(q8.size()), q8.size() == 0, q8.size() == 8, m_ovf, m_unf};
      vecs++; if (act !== exp) begin
        errs++; $display("FAIL random[%0d] got y/cnt/e/f/o/u=%h want %h", n, act, exp);
      end
    end
  endtask

`ifdef RAM_FIFO_PEEK_EN
  task automatic test_peek();
    step(0, 0, 4'h0, 1);
    step(1, 0, 4'h7, 0);
    step(1, 0, 4'h3, 0);
    step(1, 0, 4'hE, 0);
    pa = 3'd0; #1;
    vecs++; if (py !== 4'h7) begin errs++; $display("FAIL peek0 got %h want 7", py); end
    pa = 3'd2; #1;
    vecs++; if (py !== 4'hE) begin errs++; $display("FAIL peek2 got %h want e", py); end
    pa = 3'd3; #1;
    vecs++; if (py !== 4'h0) begin errs++; $display("FAIL peek3 got %h want 0", py); end
    step(0, 1, 4'h0, 0);
    pa = 3'd0; #1;
    vecs++; if (py !== 4'h3) begin errs++; $display("FAIL peek_pop got %h want 3", py); end
  endtask
`endif

  initial begin
    nr = 1; clr = 0; wr = 0; rd = 0; d = 0;
    wr5 = 0; rd5 = 0; d5 = 0;
`ifdef RAM_FIFO_PEEK_EN
    pa = 0; pa5 = 0;
`endif
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_wrap();
`ifdef RAM_FIFO_PEEK_EN
    test_peek();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
